// File: rtl/sim_pkg.sv
// Shared definitions for the simulation controller: FSM state encoding,
// dump beat kinds and the default tohost address.
package sim_pkg;

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    RUN       = 3'd1,
    DUMP_REGS = 3'd2,
    DUMP_MEM  = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic DUMP_KIND_REG = 1'b0;
  localparam logic DUMP_KIND_MEM = 1'b1;

  localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_3FFC;

  // Width of the beat index carried on the dump stream.
  localparam int DUMP_IDX_W = 16;

endpackage

// File: rtl/sim_dump_seq.sv
// Index sequencer with a valid/ready handshake. A start pulse restarts it at
// index 0; it then walks up to last_idx, advancing one step per accepted beat.
module sim_dump_seq #(
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] last_idx,
  input  logic             ready,
  output logic             valid,
  output logic [IDX_W-1:0] index,
  output logic             last_xfer
);

  logic [IDX_W-1:0] limit;

  assign last_xfer = valid && ready && (index == limit);

  // A start in the same cycle as the final transfer re-arms the sequencer,
  // so back-to-back phases run with no idle beat between them.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      valid <= 1'b0;
      index <= '0;
      limit <= '0;
    end else if (start) begin
      valid <= 1'b1;
      index <= '0;
      limit <= last_idx;
    end else if (valid && ready) begin
      if (index == limit) begin
        valid <= 1'b0;
      end else begin
        index <= index + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sim_ctrl.sv
// Simulation controller: holds the core in reset, runs it until a tohost store
// or a timeout, then streams out the register file and the low data memory.
module sim_ctrl
  import sim_pkg::*;
#(
  parameter int              XLEN           = 32,
  parameter int              NUM_REGS       = 32,
  parameter int              MEM_WORDS      = 4096,
  parameter int              DUMP_WORDS     = 4096,
  parameter int              RESET_CYCLES   = 4,
  parameter int              TIMEOUT_CYCLES = 10000,
  parameter logic [XLEN-1:0] TOHOST_ADDR    = XLEN'(DEFAULT_TOHOST_ADDR)
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         core_rst,
  input  logic                         mem_we,
  input  logic [XLEN-1:0]              mem_addr,
  input  logic [XLEN-1:0]              mem_wdata,
  output logic [$clog2(NUM_REGS)-1:0]  reg_raddr,
  input  logic [XLEN-1:0]              reg_rdata,
  output logic [$clog2(MEM_WORDS)-1:0] dmem_raddr,
  input  logic [XLEN-1:0]              dmem_rdata,
  output logic                         dump_valid,
  input  logic                         dump_ready,
  output logic                         dump_kind,
  output logic [15:0]                  dump_index,
  output logic [XLEN-1:0]              dump_data,
  output logic                         done,
  output logic                         pass,
  output logic                         timeout,
  output logic [XLEN-1:0]              exit_code,
  output logic [31:0]                  cycle_count
);

  localparam int RA_W = $clog2(NUM_REGS);
  localparam int MA_W = $clog2(MEM_WORDS);

  state_t                state;
  logic [31:0]           hold_cnt;
  logic                  tohost_hit;
  logic                  timeout_hit;
  logic                  seq_start;
  logic [DUMP_IDX_W-1:0] seq_last_idx;
  logic                  seq_valid;
  logic [DUMP_IDX_W-1:0] seq_idx;
  logic                  seq_last;

  assign tohost_hit  = (state == RUN) && mem_we && (mem_addr == TOHOST_ADDR);
  assign timeout_hit = (state == RUN) && (cycle_count == 32'(TIMEOUT_CYCLES - 1));

  // The sequencer is started once for the register phase and once more on
  // the final register transfer for the memory phase.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    seq_start    = 1'b0;
    seq_last_idx = DUMP_IDX_W'(NUM_REGS - 1);
    if (tohost_hit || timeout_hit) begin
      seq_start = 1'b1;
    end else if ((state == DUMP_REGS) && seq_last) begin
      seq_start    = 1'b1;
      seq_last_idx = DUMP_IDX_W'(DUMP_WORDS - 1);
    end
  end

  sim_dump_seq #(
    .IDX_W(DUMP_IDX_W)
  ) u_dump_seq (
    .clk      (clk),
    .rst      (rst),
    .start    (seq_start),
    .last_idx (seq_last_idx),
    .ready    (dump_ready),
    .valid    (seq_valid),
    .index    (seq_idx),
    .last_xfer(seq_last)
  );

  assign dump_valid = seq_valid;
  assign dump_index = seq_idx;
  assign reg_raddr  = (state == DUMP_REGS) ? seq_idx[RA_W-1:0] : '0;
  assign dmem_raddr = (state == DUMP_MEM)  ? seq_idx[MA_W-1:0] : '0;

  // Read data is combinational from the frozen core, so it stays stable
  // for as long as the index is held.
  assign dump_data = (dump_kind == DUMP_KIND_MEM) ? dmem_rdata : reg_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HOLD;
      hold_cnt    <= '0;
      core_rst    <= 1'b1;
      dump_kind   <= DUMP_KIND_REG;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      exit_code   <= '0;
      cycle_count <= '0;
    end else begin
      case (state)
        HOLD: begin
          if (hold_cnt == 32'(RESET_CYCLES - 1)) begin
            state    <= RUN;
            core_rst <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 32'd1;
          end
        end

        RUN: begin
          // A tohost store takes priority over a timeout in the same cycle;
          // the terminating cycle leaves cycle_count at its current value.
          if (tohost_hit) begin
            exit_code <= mem_wdata;
            pass      <= (mem_wdata == XLEN'(1));
            state     <= DUMP_REGS;
            core_rst  <= 1'b1;
            dump_kind <= DUMP_KIND_REG;
          end else if (timeout_hit) begin
            timeout   <= 1'b1;
            pass      <= 1'b0;
            state     <= DUMP_REGS;
            core_rst  <= 1'b1;
            dump_kind <= DUMP_KIND_REG;
          end else if (cycle_count != '1) begin
            cycle_count <= cycle_count + 32'd1;
          end
        end

        DUMP_REGS: begin
          if (seq_last) begin
            state     <= DUMP_MEM;
            dump_kind <= DUMP_KIND_MEM;
          end
        end

        DUMP_MEM: begin
          if (seq_last) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end

        DONE: begin
          done <= 1'b1;
        end

        default: begin
          state    <= HOLD;
          hold_cnt <= '0;
          core_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule
